// File: rtl/ahb3lite_sram_sched.sv
// ahb3lite_sram_sched: two-client command scheduler and AHB3-Lite master.
// Macro SCHED_FIXED_PRIO_EN selects fixed priority (client 0 wins) over round-robin.
module ahb3lite_sram_sched #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              write0,
  input  logic [2:0]        size0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              write1,
  input  logic [2:0]        size1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_FAIL
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_e            state_q;
  logic              owner_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              hsel_q;
  logic [1:0]        htrans_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;

  logic              open_w;
  logic              pick1;
  logic              acc;
  logic              fin;
  logic              misal;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write;
  logic [2:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;

  // New commands are taken in IDLE or on the completing data-phase cycle
  assign open_w = (state_q == S_IDLE) ||
                  (state_q == S_DATA && HREADY);

`ifdef SCHED_FIXED_PRIO_EN
  assign pick1 = req1 && !req0;
`else
  logic last_q;
  assign pick1 = req1 && (!req0 || !last_q);
`endif

  assign gnt1 = open_w && pick1;
  assign gnt0 = open_w && req0 && !pick1;
  assign acc  = gnt0 || gnt1;

  assign sel_addr  = pick1 ? addr1  : addr0;
  assign sel_write = pick1 ? write1 : write0;
  assign sel_size  = pick1 ? size1  : size0;
  assign sel_wdata = pick1 ? wdata1 : wdata0;

  assign misal = (sel_size == 3'd1 && sel_addr[0]) ||
                 (sel_size == 3'd2 && sel_addr[1:0] != 2'b00) ||
                 (sel_size > 3'd2);

  assign fin   = (state_q == S_DATA) && HREADY;
  assign done0 = (fin || state_q == S_FAIL) && !owner_q;
  assign done1 = (fin || state_q == S_FAIL) && owner_q;
  assign rdata = fin ? HRDATA : '0;
  assign err   = fin ? HRESP : (state_q == S_FAIL);

  assign HSEL   = hsel_q;
  assign HTRANS = htrans_q;
  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = hsize_q;
  assign HWDATA = hwdata_q;
  assign HBURST = 3'b000;
  assign HPROT  = HPROT_VAL;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      hsel_q   <= 1'b0;
      htrans_q <= TR_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
`ifndef SCHED_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else if (acc) begin
      owner_q  <= pick1;
      haddr_q  <= sel_addr;
      hwrite_q <= sel_write;
      hsize_q  <= sel_size;
      wdata_q  <= sel_wdata;
      hsel_q   <= !misal;
      htrans_q <= misal ? TR_IDLE : TR_NONSEQ;
      state_q  <= misal ? S_FAIL : S_ADDR;
`ifndef SCHED_FIXED_PRIO_EN
      last_q   <= pick1;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_IDLE;
        S_ADDR: begin
          if (HREADY) begin
            state_q  <= S_DATA;
            hsel_q   <= 1'b0;
            htrans_q <= TR_IDLE;
            hwdata_q <= wdata_q;
          end
        end
        S_DATA: begin
          if (HREADY) state_q <= S_IDLE;
        end
        S_FAIL: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_sched.sv
// tb_ahb3lite_sram_sched: directed bench with slave model and completion scoreboard.
// Expectations for the tie test follow SCHED_FIXED_PRIO_EN.
module tb_ahb3lite_sram_sched;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req0, req1, write0, write1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  size0, size1;
  logic        gnt0, gnt1, done0, done1, err;
  logic [31:0] rdata;
  logic        HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP  = 1'b0;

  ahb3lite_sram_sched dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .addr0(addr0), .write0(write0),
    .size0(size0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .write1(write1),
    .size1(size1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .rdata(rdata), .err(err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  initial forever #10 HCLK = ~HCLK;

  typedef struct {
    logic        c;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] smem [0:255];
  logic [31:0] rmem [0:255];
  int          errs = 0;
  int          checks = 0;
  int          ws_addr = 0;
  int          ws_data = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: alignment rule, error window at addr[11], word memory
  function automatic exp_t model(input logic c,
                                 input logic [31:0] a,
                                 input logic w,
                                 input logic [2:0] s,
                                 input logic [31:0] d);
    exp_t e;
    e.c = c;
    e.rd = '0;
    e.er = 1'b0;
    if ((s == 3'd1 && a[0]) ||
        (s == 3'd2 && a[1:0] != 2'b00) || s > 3'd2)
      e.er = 1'b1;
    else if (a[11])
      e.er = 1'b1;
    else if (w)
      rmem[a[9:2]] = d;
    else
      e.rd = rmem[a[9:2]];
    return e;
  endfunction

  // Slave model: responds at negedge from the observed bus state
  int         cnt = 0;
  logic       dp = 1'b0, dp_wr = 1'b0, dp_err = 1'b0;
  logic [7:0] dp_idx = '0;
  always @(negedge HCLK) begin
    if (HRESET) begin
      dp = 1'b0; cnt = 0;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    end else if (dp) begin
      if (cnt < ws_data) begin
        HREADY = 1'b0; HRESP = dp_err; HRDATA = '0; cnt++;
      end else begin
        HREADY = 1'b1; HRESP = dp_err;
        HRDATA = (dp_err || dp_wr) ? '0 : smem[dp_idx];
        if (dp_wr && !dp_err) smem[dp_idx] = HWDATA;
        dp = 1'b0; cnt = 0;
      end
    end else if (HSEL && HTRANS == 2'b10) begin
      HRESP = 1'b0; HRDATA = '0;
      if (cnt < ws_addr) begin
        HREADY = 1'b0; cnt++;
      end else begin
        HREADY = 1'b1; cnt = 0; dp = 1'b1;
        dp_wr = HWRITE; dp_idx = HADDR[9:2]; dp_err = HADDR[11];
      end
    end else begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    end
  end

  // Acceptance monitor: push expected completion just before the edge
  always @(negedge HCLK) begin
    #6;
    if (!HRESET) begin
      if (req0 && gnt0) sb.push_back(model(1'b0, addr0, write0, size0, wdata0));
      if (req1 && gnt1) sb.push_back(model(1'b1, addr1, write1, size1, wdata1));
    end
  end

  // Completion checker
  always @(negedge HCLK) begin
    exp_t e;
    #2;
    if (!HRESET && (done0 || done1)) begin
      chk("one_done", {31'b0, done0 && done1}, 32'd0);
      chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_owner", {31'b0, done1}, {31'b0, e.c});
        chk("done_rdata", rdata, e.rd);
        chk("done_err", {31'b0, err}, {31'b0, e.er});
      end
    end
  end

  task automatic drain(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic send(input logic c, input logic [31:0] a,
                      input logic w, input logic [2:0] s,
                      input logic [31:0] d);
    logic got;
    got = 1'b0;
    @(negedge HCLK); #3;
    if (c) begin
      req1 = 1'b1; addr1 = a; write1 = w; size1 = s; wdata1 = d;
    end else begin
      req0 = 1'b1; addr0 = a; write0 = w; size0 = s; wdata0 = d;
    end
    for (int i = 0; i < 50; i++) begin
      #1;
      if (c ? gnt1 : gnt0) begin got = 1'b1; break; end
      @(negedge HCLK); #3;
    end
    chk("send_gnt", {31'b0, got}, 32'd1);
    @(posedge HCLK); #1;
    if (c) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_hsel"},   {31'b0, HSEL}, 32'd0);
    chk({p, "_htrans"}, {30'b0, HTRANS}, 32'd0);
    chk({p, "_haddr"},  HADDR, 32'd0);
    chk({p, "_hwrite"}, {31'b0, HWRITE}, 32'd0);
    chk({p, "_hsize"},  {29'b0, HSIZE}, 32'd0);
    chk({p, "_hwdata"}, HWDATA, 32'd0);
    chk({p, "_hburst"}, {29'b0, HBURST}, 32'd0);
    chk({p, "_hprot"},  {28'b0, HPROT}, 32'd3);
    chk({p, "_gnt"},    {30'b0, gnt1, gnt0}, 32'd0);
    chk({p, "_done"},   {30'b0, done1, done0}, 32'd0);
    chk({p, "_err"},    {31'b0, err}, 32'd0);
    chk({p, "_rdata"},  rdata, 32'd0);
  endtask

  initial begin
    int g[4];
    int n, nd, first;
    HRESET = 1'b1;
    req0 = 0; req1 = 0; write0 = 0; write1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    size0 = '0; size1 = '0;
    for (int i = 0; i < 256; i++) begin
      smem[i] = '0; rmem[i] = '0;
    end
    @(negedge HCLK); #4;
    chk_rst("rst");
    @(negedge HCLK); #3;
    HRESET = 1'b0;

    // Single write then read
    @(negedge HCLK); #3;
    req0 = 1; addr0 = 32'h10; write0 = 1; size0 = 3'd2;
    wdata0 = 32'hDEADBEEF;
    #1;
    chk("t1_gnt0", {31'b0, gnt0}, 32'd1);
    chk("t1_gnt1", {31'b0, gnt1}, 32'd0);
    @(posedge HCLK); #1; req0 = 0;
    @(negedge HCLK); #4;
    chk("t1_hsel", {31'b0, HSEL}, 32'd1);
    chk("t1_htrans", {30'b0, HTRANS}, 32'd2);
    chk("t1_haddr", HADDR, 32'h10);
    chk("t1_hwrite", {31'b0, HWRITE}, 32'd1);
    chk("t1_hsize", {29'b0, HSIZE}, 32'd2);
    @(negedge HCLK); #4;
    chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
    chk("t1_done0", {31'b0, done0}, 32'd1);
    chk("t1_dtrans", {30'b0, HTRANS}, 32'd0);
    send(1'b1, 32'h10, 1'b0, 3'd2, '0);
    drain(4);

    // Both clients requesting continuously
    @(posedge HCLK); #1;
    req0 = 1; addr0 = 32'h10; write0 = 0; size0 = 3'd2;
    req1 = 1; addr1 = 32'h20; write1 = 0; size1 = 3'd2;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge HCLK); #4;
      chk("tie_one_gnt", {31'b0, gnt0 && gnt1}, 32'd0);
      if (gnt0) begin g[n] = 0; n++; end
      else if (gnt1) begin g[n] = 1; n++; end
    end
    @(posedge HCLK); #1; req0 = 0; req1 = 0;
    chk("tie_count", n, 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef SCHED_FIXED_PRIO_EN
      chk("tie_grant", g[i], 32'd0);
`else
      chk("tie_grant", g[i], i % 2);
`endif
    end
    drain(4);

    // Wait states: 3 in address phase, 2 in data phase
    ws_addr = 3; ws_data = 2;
    @(negedge HCLK); #3;
    req0 = 1; addr0 = 32'h40; write0 = 1; size0 = 3'd2;
    wdata0 = 32'h12345678;
    #1; chk("ws_gnt0", {31'b0, gnt0}, 32'd1);
    @(posedge HCLK); #1; req0 = 0;
    nd = 0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge HCLK); #4;
      if (i <= 4) begin
        chk("ws_atrans", {30'b0, HTRANS}, 32'd2);
        chk("ws_haddr", HADDR, 32'h40);
      end else if (i <= 7) begin
        chk("ws_dtrans", {30'b0, HTRANS}, 32'd0);
        chk("ws_hwdata", HWDATA, 32'h12345678);
      end
      if (done0) begin
        nd++;
        if (first == 0) first = i;
      end
    end
    chk("ws_ndone", nd, 32'd1);
    chk("ws_latency", first, 32'd7);
    ws_addr = 0; ws_data = 0;
    send(1'b1, 32'h40, 1'b0, 3'd2, '0);
    drain(4);

    // ERROR response with a queued command from client 1
    ws_data = 1;
    @(negedge HCLK); #3;
    req0 = 1; addr0 = 32'h800; write0 = 0; size0 = 3'd2;
    #1; chk("er_gnt0", {31'b0, gnt0}, 32'd1);
    @(posedge HCLK); #1;
    req0 = 0;
    req1 = 1; addr1 = 32'h10; write1 = 0; size1 = 3'd2;
    @(negedge HCLK); #4;
    chk("er_atrans", {30'b0, HTRANS}, 32'd2);
    @(negedge HCLK); #4;
    chk("er_wait_done", {31'b0, done0}, 32'd0);
    chk("er_wait_gnt1", {31'b0, gnt1}, 32'd0);
    chk("er_dtrans", {30'b0, HTRANS}, 32'd0);
    @(negedge HCLK); #4;
    chk("er_done0", {31'b0, done0}, 32'd1);
    chk("er_err", {31'b0, err}, 32'd1);
    chk("er_gnt1", {31'b0, gnt1}, 32'd1);
    @(posedge HCLK); #1; req1 = 0;
    drain(4);
    ws_data = 0;

    // Misaligned commands
    @(negedge HCLK); #3;
    req1 = 1; addr1 = 32'h12; write1 = 0; size1 = 3'd2;
    #1; chk("ma_gnt1", {31'b0, gnt1}, 32'd1);
    @(posedge HCLK); #1; req1 = 0;
    @(negedge HCLK); #4;
    chk("ma_done1", {31'b0, done1}, 32'd1);
    chk("ma_err", {31'b0, err}, 32'd1);
    chk("ma_rdata", rdata, 32'd0);
    chk("ma_hsel", {31'b0, HSEL}, 32'd0);
    chk("ma_htrans", {30'b0, HTRANS}, 32'd0);
    @(negedge HCLK); #4;
    chk("ma_one_cycle", {31'b0, done1}, 32'd0);
    send(1'b0, 32'h13, 1'b0, 3'd1, '0);
    send(1'b0, 32'h10, 1'b0, 3'd3, '0);
    send(1'b1, 32'h12, 1'b0, 3'd1, '0);
    drain(4);

    // Reset during the data phase
    ws_data = 3;
    @(negedge HCLK); #3;
    req1 = 1; addr1 = 32'h80; write1 = 1; size1 = 3'd2;
    wdata1 = 32'hCAFEF00D;
    #1; chk("rm_gnt1", {31'b0, gnt1}, 32'd1);
    @(posedge HCLK); #1; req1 = 0;
    @(negedge HCLK);
    @(negedge HCLK); #3;
    chk("rm_in_data", {30'b0, HTRANS}, 32'd0);
    HRESET = 1'b1;
    sb.delete();
    #1;
    chk_rst("rm");
    @(negedge HCLK); #3;
    HRESET = 1'b0;
    ws_data = 0;
    req0 = 1; addr0 = 32'h10; write0 = 0; size0 = 3'd2;
    req1 = 1; addr1 = 32'h20; write1 = 0; size1 = 3'd2;
    #1;
    chk("rm_tie_gnt0", {31'b0, gnt0}, 32'd1);
    chk("rm_tie_gnt1", {31'b0, gnt1}, 32'd0);
    req1 = 0;
    @(posedge HCLK); #1; req0 = 0;
    drain(6);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb3lite_sram_sched.md
Name: ahb3lite_sram_sched

Overview:
- Two-requester command scheduler and AHB3-Lite master front end for the single-port AHB3-Lite SRAM slave.
- Accepts single-transfer read/write commands from two clients over valid/ready ports, arbitrates between them, and drives one SINGLE/NONSEQ transfer at a time.
- Returns read data, completion and error status to the owning client.
- Sits between system clients and the SRAM slave; its H* outputs connect directly to the slave's H* inputs.

Parameters:
- ADDR_W, 32, address width of HADDR and client addresses.
- DATA_W, 32, data width; fixed at 32 (byte lanes derived from HSIZE).
- HPROT_VAL, 4'b0011, constant HPROT value driven on every transfer (data access, privileged).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  client command valid.
- addr0 / addr1  in  ADDR_W  client byte address.
- write0 / write1  in  1  1 = write, 0 = read.
- size0 / size1  in  3  HSIZE encoding; only 0, 1, 2 are legal.
- wdata0 / wdata1  in  DATA_W  write data, AHB lane-aligned.
- gnt0 / gnt1  out  1  command accepted (combinational ready).
- done0 / done1  out  1  one-cycle completion pulse to the owning client.
- rdata  out  DATA_W  read data; valid only while done0 or done1 is high.
- err  out  1  error flag; valid only while done0 or done1 is high.
- HSEL  out  1  slave select.
- HADDR  out  ADDR_W  address.
- HTRANS  out  2  transfer type.
- HWRITE  out  1  write control.
- HSIZE  out  3  transfer size.
- HBURST  out  3  burst type; always 3'b000.
- HPROT  out  4  protection control; always HPROT_VAL.
- HWDATA  out  DATA_W  write data.
- HRDATA  in  DATA_W  slave read data.
- HREADY  in  1  transfer ready (slave HREADYOUT fed back).
- HRESP  in  1  slave response; 1 = ERROR.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - HSEL=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - gnt*, done*, err = 0; rdata = 0.
  - last_grant = 1, so client 0 wins the first tie.
- HBURST is always 3'b000 and HPROT is always HPROT_VAL, including during reset.
- Handshake:
  - A command transfers on a rising edge where reqN && gntN.
  - gnt is asserted only in IDLE, or in DATA in the cycle HREADY=1 (completion).
  - At most one gnt is high per cycle.
  - The client holds its fields stable while req is high and gnt is low.
  - All fields are latched into command registers at acceptance.
- Arbitration:
  - Round-robin; when both clients request, grant the client that is not last_grant.
  - last_grant updates on every acceptance.
- States:
  - IDLE: HSEL=0, HTRANS=IDLE. On acceptance -> ADDR, or -> FAIL if the command is misaligned.
  - ADDR:
    - Drive HSEL=1, HTRANS=NONSEQ, and HADDR/HWRITE/HSIZE from the command registers.
    - HREADY=0: hold all of these stable and stay in ADDR.
    - HREADY=1: -> DATA.
  - DATA:
    - Drive HSEL=0, HTRANS=IDLE, and HWDATA from the latched wdata (HWDATA holds its value in other states).
    - HREADY=0: stay in DATA; HRESP=1 here is the first ERROR cycle, no action.
    - HREADY=1: pulse done for the owner, rdata=HRDATA, err=HRESP.
    - On that same cycle: new acceptance -> ADDR (or FAIL if misaligned); no acceptance -> IDLE.
  - FAIL: one cycle; pulse done with err=1, rdata=0, no bus activity; -> IDLE.
- Alignment check: a command is misaligned if size=1 and addr[0]=1, size=2 and addr[1:0]!=0, or size>2.
- Timing: best-case latency from acceptance edge to done is 2 cycles (ADDR, then DATA). Throughput is one transfer per 2 cycles; there is exactly one outstanding transfer.
- ERROR response: the block never cancels a transfer, because HTRANS is already IDLE during the data phase. The ERROR response is reported to the client unmodified.
- If a client drops req without getting gnt, the command is withdrawn; no state change.

Optional Feature:
- Macro: SCHED_FIXED_PRIO_EN.
  - Defined: fixed priority, client 0 always wins over client 1; last_grant is unused.
  - Undefined: round-robin as specified above.

Test Plan:
- Single write then read: req0 write addr=0x10, size=2, wdata=0xDEADBEEF, HREADY=1; then read 0x10.
  - gnt0 at cycle 0; NONSEQ with HADDR=0x10 at cycle 1; HWDATA=0xDEADBEEF at cycle 2 with done0.
  - The read returns rdata=0xDEADBEEF with err=0.
- Both requesting after reset: req0 and req1 held high continuously.
  - Grants alternate 0,1,0,1.
  - With SCHED_FIXED_PRIO_EN defined: grants are 0,0,0 and client 1 is starved.
- Wait states: slave holds HREADY=0 for 3 cycles in ADDR and 2 cycles in DATA.
  - HADDR/HTRANS/HWDATA stay stable throughout.
  - done fires exactly once, 7 cycles after acceptance.
- Error response: HRESP=1/HREADY=0, then HRESP=1/HREADY=1.
  - done high with err=1 in the second cycle.
  - The next queued command is accepted on that same cycle.
- Misaligned command: size=2, addr=0x12.
  - Accepted, then a FAIL cycle: done with err=1; HSEL and HTRANS stay 0.
- Reset mid-operation: assert HRESET while in DATA.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - No done pulse is generated.
  - After release, the first tie grants client 0.
